// File: rtl/mux_scan_serializer.sv
// Scan driver/collector for an N-to-1 mux: drives a loaded word onto the mux data inputs,
// walks the select lines, samples the mux output after a settle delay and streams the bits out.
module mux_scan_serializer #(
    parameter int DATA_W     = 8,
    parameter int SEL_W      = 4,
    parameter int NUM_CH     = 8,
    parameter int SETTLE_CYC = 1,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] mux_data,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic              mux_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_bit,
    output logic              ser_last,
    output logic              busy,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the source
    // keeps valid and its payload stable until that edge and never drops valid early.

    localparam int                CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0]  LAST_SEL    = SEL_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mux_data;
    logic [SEL_W-1:0]    r_mux_sel;
    logic [CNT_W-1:0]    r_settle_cnt;
    logic                r_ser_valid;
    logic                r_ser_bit;
    logic                r_ser_last;
    logic [ERR_W-1:0]    r_err_cnt;

    logic                w_accept;
    logic                w_sample;
    logic                w_handshake;
    logic [DATA_W-1:0]   w_data_shift;
    logic [31:0]         w_sel_ext;
    logic                w_exp_bit;
    logic                w_mismatch;

    // Selects beyond the data width see no driven input, so the mux should read 0 there.
    assign w_data_shift = r_mux_data >> r_mux_sel;
    assign w_sel_ext    = 32'(r_mux_sel);
    assign w_exp_bit    = (w_sel_ext < 32'(DATA_W)) ? w_data_shift[0] : 1'b0;
    assign w_mismatch   = (mux_out != w_exp_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (r_ser_valid && ser_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = r_ser_last ? ST_IDLE : ST_SETTLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mux_data   <= '0;
            r_mux_sel    <= '0;
            r_settle_cnt <= '0;
            r_ser_valid  <= 1'b0;
            r_ser_bit    <= 1'b0;
            r_ser_last   <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_mux_data   <= load_data;
                r_mux_sel    <= '0;
                r_settle_cnt <= '0;
            end
            if (r_state == ST_SETTLE && !w_sample) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end
            if (w_sample) begin
                r_ser_bit   <= mux_out;
                r_ser_valid <= 1'b1;
                r_ser_last  <= (r_mux_sel == LAST_SEL);
                if (w_mismatch && (r_err_cnt != '1)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
            // Data and select are left as-is after the final bit so the mux stays quiet.
            if (w_handshake) begin
                r_ser_valid <= 1'b0;
                r_ser_last  <= 1'b0;
                if (!r_ser_last) begin
                    r_mux_sel    <= r_mux_sel + 1'b1;
                    r_settle_cnt <= '0;
                end
            end
        end
    end

    assign load_ready = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign mux_data   = r_mux_data;
    assign mux_sel    = r_mux_sel;
    assign ser_valid  = r_ser_valid;
    assign ser_bit    = r_ser_bit;
    assign ser_last   = r_ser_last;
    assign err_cnt    = r_err_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Randomized bench for mux_scan_serializer: a behavioural mux with injectable faults feeds
// the DUT; a frame-level reference model predicts the bit stream, timing and error count.
module tb_mux_scan_serializer;

    localparam int DATA_W     = 8;
    localparam int SEL_W      = 4;
    localparam int NUM_CH     = 16;
    localparam int SETTLE_CYC = 2;
    localparam int ERR_W      = 8;
    localparam int FRAME_CYC  = NUM_CH * (SETTLE_CYC + 1);
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [DATA_W-1:0] load_data = '0;
    logic [DATA_W-1:0] mux_data;
    logic [SEL_W-1:0]  mux_sel;
    logic              mux_out;
    logic              ser_valid;
    logic              ser_ready = 1'b0;
    logic              ser_bit;
    logic              ser_last;
    logic              busy;
    logic [ERR_W-1:0]  err_cnt;
    logic [1:0]        dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mux_scan_serializer #(
        .DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_CH(NUM_CH),
        .SETTLE_CYC(SETTLE_CYC), .ERR_W(ERR_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .mux_data(mux_data), .mux_sel(mux_sel), .mux_out(mux_out),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_bit(ser_bit), .ser_last(ser_last),
        .busy(busy), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    // Behavioural mux: undriven channels read 0; flip_mask injects per-channel faults.
    logic [NUM_CH-1:0] flip_mask = '0;
    logic [DATA_W-1:0] mux_shift;
    always_comb begin
        mux_shift = mux_data >> mux_sel;
        mux_out   = mux_shift[0] ^ flip_mask[mux_sel];
    end

    // ---------------- checking ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [1:0]        exp_q[$];          // {last, bit}
    int                exp_err = 0;
    int                frame_err = 0;
    int                accepts = 0;
    int                accept_edge = 0;
    int                done_edge = 0;
    int                last_hs_edge = 0;
    int                bits_done = 0;
    int                ready_mode = 0;    // 0 tied high, 1 toggle, 2 random
    int                b2b_base = -1;
    logic              pending_end = 1'b0;
    logic              frame_tied = 1'b0;
    logic              seen_first = 1'b0;
    logic              prev_stall = 1'b0;
    logic              prev_bit = 1'b0;
    logic              prev_last = 1'b0;
    logic [DATA_W-1:0] cur_word = '0;

    always @(negedge clk) begin
        logic [1:0] e;
        logic       ideal;
        if (!rst_n) begin
            exp_q.delete();
            exp_err     = 0;
            pending_end = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            if (pending_end && cyc == done_edge) begin
                pending_end = 1'b0;
                exp_err = (exp_err + frame_err > ERR_MAX) ? ERR_MAX : exp_err + frame_err;
                check_eq("ready_after_last", load_ready, 1);
                check_eq("err_cnt", err_cnt, exp_err);
                if (frame_tied) check_eq("frame_len", done_edge - accept_edge, FRAME_CYC);
            end
            check_eq("ready_vs_busy", load_ready, !busy);
            if (busy) begin
                check_eq("mux_data", mux_data, cur_word);
                check_eq("mux_sel", mux_sel, bits_done);
            end
            if (ser_valid) begin
                if (!seen_first) begin
                    seen_first = 1'b1;
                    check_eq("first_latency", cyc - accept_edge, SETTLE_CYC);
                end
                if (prev_stall) begin
                    check_eq("stall_bit", ser_bit, prev_bit);
                    check_eq("stall_last", ser_last, prev_last);
                end
                if (ser_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_bit", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("ser_bit", ser_bit, e[0]);
                        check_eq("ser_last", ser_last, e[1]);
                    end
                    bits_done++;
                    if (ser_last) begin
                        pending_end  = 1'b1;
                        done_edge    = cyc + 1;
                        last_hs_edge = cyc + 1;
                    end
                end
            end else if (prev_stall) begin
                check_eq("stall_valid_drop", 0, 1);
            end
            prev_stall = ser_valid && !ser_ready;
            prev_bit   = ser_bit;
            prev_last  = ser_last;

            if (load_valid && load_ready) begin
                if (b2b_base >= 0 && accepts > b2b_base)
                    check_eq("b2b_gap", (cyc + 1) - last_hs_edge, 1);
                accepts++;
                accept_edge = cyc + 1;
                cur_word    = load_data;
                bits_done   = 0;
                seen_first  = 1'b0;
                frame_tied  = (ready_mode == 0);
                frame_err   = $countones(flip_mask);
                for (int i = 0; i < NUM_CH; i++) begin
                    ideal = (i < DATA_W) ? load_data[i] : 1'b0;
                    exp_q.push_back({(i == NUM_CH - 1), ideal ^ flip_mask[i]});
                end
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ser_ready = 1'b1;
                1:       ser_ready = !ser_ready;
                default: ser_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic load_word(input logic [DATA_W-1:0] w, input logic [NUM_CH-1:0] m);
        int a0;
        a0 = accepts;
        @(posedge clk);
        #1;
        flip_mask  = m;
        load_data  = w;
        load_valid = 1'b1;
        for (int i = 0; i < 100 && accepts == a0; i++) @(posedge clk);
        #1;
        load_valid = 1'b0;
        if (accepts == a0) check_eq("load_timeout", 0, 1);
    endtask

    task automatic wait_frame_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || pending_end || exp_q.size() != 0) && n < 3000);
        if (n >= 3000) check_eq("frame_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [DATA_W-1:0] w, input logic [NUM_CH-1:0] m, input int mode);
        ready_mode = mode;
        load_word(w, m);
        wait_frame_done();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_mux_data"}, mux_data, 0);
        check_eq({tag, "_mux_sel"}, mux_sel, 0);
        check_eq({tag, "_ser_valid"}, ser_valid, 0);
        check_eq({tag, "_ser_bit"}, ser_bit, 0);
        check_eq({tag, "_ser_last"}, ser_last, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_err_cnt"}, err_cnt, 0);
        check_eq({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [NUM_CH-1:0] m;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", load_ready, 1);

        run_frame(8'hAA, '0, 0);                 // alternating word, tied ready
        run_frame(8'hAA, '0, 1);                 // ready toggling every cycle
        run_frame(8'hFF, '0, 0);                 // upper channels must read 0
        run_frame(8'h00, NUM_CH'(1 << 6), 0);    // single stuck-at-1 at select 6
        check_eq("single_fault_err", err_cnt, 1);

        for (int f = 0; f < 20; f++) begin
            m = NUM_CH'($urandom() & $urandom() & $urandom());
            run_frame(DATA_W'($urandom()), m, $urandom_range(0, 2));
        end
        for (int f = 0; f < 18; f++) run_frame(DATA_W'($urandom()), '1, 0);
        check_eq("err_saturated", err_cnt, ERR_MAX);

        // Abort a frame with reset after three bits have gone out.
        ready_mode = 0;
        load_word(8'hAA, '0);
        n = 0;
        while (bits_done < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("abort_wait_timeout", 0, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("abort");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_abort", load_ready, 1);
        run_frame(8'h55, '0, 0);

        // load_valid held through a frame: next word only after the final handshake.
        ready_mode = 0;
        b2b_base   = accepts + 1;
        @(posedge clk);
        #1;
        flip_mask  = '0;
        load_data  = 8'h3C;
        load_valid = 1'b1;
        n = 0;
        while (accepts < b2b_base + 1 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1 load_valid = 1'b0;
        if (n >= 500) check_eq("b2b_timeout", 0, 1);
        wait_frame_done();
        b2b_base = -1;

        for (int f = 0; f < 6; f++) run_frame(DATA_W'($urandom()), '0, $urandom_range(0, 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
